// File: rtl/cv32e40p_apu_responder.sv
// Shared-unit side of the APU request/response interface.
// Simple integer ops run through a LAT-deep shift register whose last stage is
// the response register. DIVU runs on an iterative restoring divider that loads
// that same response register when it finishes.
// Handshake: a request transfers in any cycle where apu_req_i & apu_gnt_o.
// Each transfer yields exactly one single-cycle apu_rvalid_o pulse, in order.
// The response channel has no back-pressure.
module cv32e40p_apu_responder #(
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5,
  parameter int LAT              = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                apu_req_i,
  output logic                                apu_gnt_o,
  input  logic [APU_NARGS_CPU-1:0][31:0]      apu_operands_i,
  input  logic [APU_WOP_CPU-1:0]              apu_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]         apu_flags_i,
  output logic                                apu_rvalid_o,
  output logic [31:0]                         apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]         apu_rflags_o,
  output logic                                busy_o
);

  localparam logic [APU_WOP_CPU-1:0] OP_ADD   = APU_WOP_CPU'(0);
  localparam logic [APU_WOP_CPU-1:0] OP_SUB   = APU_WOP_CPU'(1);
  localparam logic [APU_WOP_CPU-1:0] OP_MIN   = APU_WOP_CPU'(2);
  localparam logic [APU_WOP_CPU-1:0] OP_MAX   = APU_WOP_CPU'(3);
  localparam logic [APU_WOP_CPU-1:0] OP_MULLO = APU_WOP_CPU'(4);
  localparam logic [APU_WOP_CPU-1:0] OP_DIVU  = APU_WOP_CPU'(5);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Downstream flags and the third operand are accepted but carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^apu_flags_i ^ ^apu_operands_i;

  logic [1:0]  state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;   // dividend shifts out at the top, quotient bits enter at the bottom
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dz_q, dz_d;

  logic [LAT-1:0]              pv_q, pv_d;
  logic [31:0]                 pr_q [LAT];
  logic [31:0]                 pr_d [LAT];
  logic [APU_NUSFLAGS_CPU-1:0] pf_q [LAT];
  logic [APU_NUSFLAGS_CPU-1:0] pf_d [LAT];

  logic [31:0]                 op_a, op_b, sum, dif, c_res;
  logic [APU_NUSFLAGS_CPU-1:0] c_flg;
  logic                        issue_v, div_fin;
  logic [32:0]                 rem_sh, rem_sub;
  logic [31:0]                 div_q_final;

  // A DIVU must wait for an empty pipeline so the two result sources never collide.
  assign apu_gnt_o = apu_req_i & rst_n & (state_q == S_IDLE) &
                     ((apu_op_i != OP_DIVU) | ~(|pv_q));
  assign issue_v   = apu_gnt_o & (apu_op_i != OP_DIVU);
  assign div_fin   = (state_q == S_DIV) && (cnt_q == 5'd31);
  assign busy_o    = (|pv_q) | (state_q != S_IDLE);

  assign apu_rvalid_o = pv_q[LAT-1];
  assign apu_result_o = pr_q[LAT-1];
  assign apu_rflags_o = pf_q[LAT-1];

  // Single-cycle ALU for the pipelined ops; flags {NV, DZ, OF, 0, 0}.
  always_comb begin
    op_a  = apu_operands_i[0];
    op_b  = apu_operands_i[1];
    sum   = op_a + op_b;
    dif   = op_a - op_b;
    c_res = '0;
    c_flg = '0;
    case (apu_op_i)
      OP_ADD: begin
        c_res    = sum;
        c_flg[2] = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
      end
      OP_SUB: begin
        c_res    = dif;
        c_flg[2] = (op_a[31] != op_b[31]) && (dif[31] != op_a[31]);
      end
      OP_MIN:   c_res = ($signed(op_a) < $signed(op_b)) ? op_a : op_b;
      OP_MAX:   c_res = ($signed(op_a) > $signed(op_b)) ? op_a : op_b;
      OP_MULLO: c_res = op_a * op_b;
      default:  c_flg[4] = 1'b1;
    endcase
  end

  // One restoring-division step per cycle, plus the IDLE/DIV/DONE sequencing.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    dz_d        = dz_q;
    rem_sh      = {rem_q, dvd_q[31]};
    rem_sub     = rem_sh - {1'b0, dvs_q};
    div_q_final = '0;
    case (state_q)
      S_IDLE: begin
        if (apu_gnt_o && (apu_op_i == OP_DIVU)) begin
          state_d = S_DIV;
          rem_d   = '0;
          dvd_d   = op_a;
          dvs_d   = op_b;
          cnt_d   = '0;
          dz_d    = (op_b == 32'd0);
        end
      end
      S_DIV: begin
        if (!rem_sub[32]) begin
          rem_d = rem_sub[31:0];
          dvd_d = {dvd_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[31:0];
          dvd_d = {dvd_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (div_fin) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    div_q_final = dz_q ? 32'hFFFF_FFFF : dvd_d;
  end

  // Shift register advance; the last stage holds its data while no valid arrives.
  always_comb begin
    pv_d = '0;
    for (int k = 0; k < LAT; k++) begin
      pr_d[k] = pr_q[k];
      pf_d[k] = pf_q[k];
    end
    pv_d[0] = issue_v;
    if ((LAT > 1) || issue_v) begin
      pr_d[0] = c_res;
      pf_d[0] = c_flg;
    end
    for (int k = 1; k < LAT; k++) begin
      pv_d[k] = pv_q[k-1];
      if ((k < LAT-1) || pv_q[k-1]) begin
        pr_d[k] = pr_q[k-1];
        pf_d[k] = pf_q[k-1];
      end
    end
    if (div_fin) begin
      pv_d[LAT-1]    = 1'b1;
      pr_d[LAT-1]    = div_q_final;
      pf_d[LAT-1]    = '0;
      pf_d[LAT-1][3] = dz_q;
    end
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      pv_q    <= '0;
      for (int k = 0; k < LAT; k++) begin
        pr_q[k] <= '0;
        pf_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      pv_q    <= pv_d;
      for (int k = 0; k < LAT; k++) begin
        pr_q[k] <= pr_d[k];
        pf_q[k] <= pf_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_apu_responder.sv
// Directed bench for cv32e40p_apu_responder with LAT=2.
// Cycle convention: inputs are driven just after a falling edge and sampled by the
// next rising edge. The cycle in which that rising edge grants a request is cycle t.
// Outputs are read 1ns after later falling edges.
module tb_cv32e40p_apu_responder;

  localparam int LAT = 2;

  logic             clk;
  logic             rst_n;
  logic             req;
  logic             gnt;
  logic [2:0][31:0] ops;
  logic [5:0]       op;
  logic [14:0]      dflags;
  logic             rvalid;
  logic [31:0]      result;
  logic [4:0]       rflags;
  logic             busy;

  int vec;
  int errs;

  cv32e40p_apu_responder #(.LAT(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .apu_req_i      (req),
    .apu_gnt_o      (gnt),
    .apu_operands_i (ops),
    .apu_op_i       (op),
    .apu_flags_i    (dflags),
    .apu_rvalid_o   (rvalid),
    .apu_result_o   (result),
    .apu_rflags_o   (rflags),
    .busy_o         (busy)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errs=%0d", errs);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    req    = r;
    op     = o;
    ops[0] = a;
    ops[1] = b;
    ops[2] = 32'hDEAD_BEEF;
    dflags = 15'h1234;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 6'd0, 32'd1, 32'd1);
    tick(); #1;
    vec++; if (gnt !== 1'b0) begin errs++; $display("FAIL reset_gnt: got %0b want 0", gnt); end
    tick(); tick(); #1;
    vec++; if (rvalid !== 1'b0) begin errs++; $display("FAIL reset_rvalid: got %0b want 0", rvalid); end
    vec++; if (result !== 32'd0) begin errs++; $display("FAIL reset_result: got %0h want 0", result); end
    vec++; if (rflags !== 5'd0) begin errs++; $display("FAIL reset_rflags: got %0h want 0", rflags); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %0b want 0", busy); end
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_add_latency();
    tick(); drive(1'b1, 6'd0, 32'd5, 32'd7); #1;
    vec++; if (gnt !== 1'b1) begin errs++; $display("FAIL add_gnt: got %0b want 1", gnt); end
    tick(); drive(1'b0, 6'd0, 32'd0, 32'd0); #1;
    vec++; if (rvalid !== 1'b0) begin errs++; $display("FAIL add_early_rvalid: got %0b want 0", rvalid); end
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL add_busy: got %0b want 1", busy); end
    tick(); #1;
    vec++; if (rvalid !== 1'b1) begin errs++; $display("FAIL add_rvalid: got %0b want 1", rvalid); end
    vec++; if (result !== 32'd12) begin errs++; $display("FAIL add_result: got %0h want c", result); end
    vec++; if (rflags !== 5'd0) begin errs++; $display("FAIL add_flags: got %0h want 0", rflags); end
    tick(); #1;
    vec++; if (rvalid !== 1'b0) begin errs++; $display("FAIL add_pulse: got %0b want 0", rvalid); end
    vec++; if (result !== 32'd12) begin errs++; $display("FAIL add_hold: got %0h want c", result); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL add_idle: got %0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    tick(); drive(1'b1, 6'd0, 32'h7FFF_FFFF, 32'd1); #1;
    vec++; if (gnt !== 1'b1) begin errs++; $display("FAIL b2b_gnt0: got %0b want 1", gnt); end
    tick(); drive(1'b1, 6'd1, 32'd3, 32'd5); #1;
    vec++; if (gnt !== 1'b1) begin errs++; $display("FAIL b2b_gnt1: got %0b want 1", gnt); end
    tick(); drive(1'b0, 6'd0, 32'd0, 32'd0); #1;
    vec++; if (rvalid !== 1'b1) begin errs++; $display("FAIL b2b_rv0: got %0b want 1", rvalid); end
    vec++; if (result !== 32'h8000_0000) begin errs++; $display("FAIL b2b_res0: got %0h want 80000000", result); end
    vec++; if (rflags !== 5'b00100) begin errs++; $display("FAIL b2b_of0: got %0h want 4", rflags); end
    tick(); #1;
    vec++; if (rvalid !== 1'b1) begin errs++; $display("FAIL b2b_rv1: got %0b want 1", rvalid); end
    vec++; if (result !== 32'hFFFF_FFFE) begin errs++; $display("FAIL b2b_res1: got %0h want fffffffe", result); end
    vec++; if (rflags !== 5'b00000) begin errs++; $display("FAIL b2b_of1: got %0h want 0", rflags); end
    tick(); #1;
    vec++; if (rvalid !== 1'b0) begin errs++; $display("FAIL b2b_rv2: got %0b want 0", rvalid); end
  endtask

  task automatic test_divu();
    tick(); drive(1'b1, 6'd5, 32'd100, 32'd7); #1;
    vec++; if (gnt !== 1'b1) begin errs++; $display("FAIL divu_gnt: got %0b want 1", gnt); end
    for (int k = 1; k <= 33; k++) begin
      tick(); drive(1'b1, 6'd0, 32'd1, 32'd2); #1;
      vec++; if (gnt !== 1'b0) begin errs++; $display("FAIL divu_block k=%0d: got %0b want 0", k, gnt); end
      vec++; if (busy !== 1'b1) begin errs++; $display("FAIL divu_busy k=%0d: got %0b want 1", k, busy); end
      vec++; if (rvalid !== (k == 33)) begin errs++; $display("FAIL divu_rvalid k=%0d: got %0b want %0b", k, rvalid, (k == 33)); end
      if (k == 33) begin
        vec++; if (result !== 32'd14) begin errs++; $display("FAIL divu_result: got %0h want e", result); end
        vec++; if (rflags !== 5'd0) begin errs++; $display("FAIL divu_flags: got %0h want 0", rflags); end
      end
    end
    tick(); #1;
    vec++; if (gnt !== 1'b1) begin errs++; $display("FAIL divu_release_gnt: got %0b want 1", gnt); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL divu_release_busy: got %0b want 0", busy); end
    tick(); drive(1'b0, 6'd0, 32'd0, 32'd0);
    tick(); #1;
    vec++; if (rvalid !== 1'b1 || result !== 32'd3) begin errs++; $display("FAIL divu_next_add: got rv=%0b res=%0h want rv=1 res=3", rvalid, result); end
  endtask

  task automatic test_order();
    int n;
    tick(); drive(1'b1, 6'd4, 32'd3, 32'd4); #1;
    vec++; if (gnt !== 1'b1) begin errs++; $display("FAIL ord_mul_gnt: got %0b want 1", gnt); end
    tick(); drive(1'b1, 6'd5, 32'd100, 32'd10); #1;
    vec++; if (gnt !== 1'b0) begin errs++; $display("FAIL ord_div_wait1: got %0b want 0", gnt); end
    tick(); #1;
    vec++; if (gnt !== 1'b0) begin errs++; $display("FAIL ord_div_wait2: got %0b want 0", gnt); end
    vec++; if (rvalid !== 1'b1 || result !== 32'd12) begin errs++; $display("FAIL ord_mul_res: got rv=%0b res=%0h want rv=1 res=c", rvalid, result); end
    tick(); #1;
    vec++; if (gnt !== 1'b1) begin errs++; $display("FAIL ord_div_gnt: got %0b want 1", gnt); end
    n = 0;
    do begin
      tick(); drive(1'b0, 6'd0, 32'd0, 32'd0); #1;
      n++;
    end while (rvalid !== 1'b1 && n < 60);
    vec++; if (n !== 33) begin errs++; $display("FAIL ord_div_latency: got %0d want 33", n); end
    vec++; if (result !== 32'd10) begin errs++; $display("FAIL ord_div_res: got %0h want a", result); end
  endtask

  task automatic test_dz_illegal();
    tick(); drive(1'b1, 6'd5, 32'd9, 32'd0); #1;
    vec++; if (gnt !== 1'b1) begin errs++; $display("FAIL dz_gnt: got %0b want 1", gnt); end
    for (int k = 1; k <= 33; k++) begin
      tick(); drive(1'b0, 6'd0, 32'd0, 32'd0);
    end
    #1;
    vec++; if (rvalid !== 1'b1) begin errs++; $display("FAIL dz_rvalid: got %0b want 1", rvalid); end
    vec++; if (result !== 32'hFFFF_FFFF) begin errs++; $display("FAIL dz_result: got %0h want ffffffff", result); end
    vec++; if (rflags !== 5'b01000) begin errs++; $display("FAIL dz_flags: got %0h want 8", rflags); end
    tick(); drive(1'b1, 6'd63, 32'd8, 32'd9); #1;
    vec++; if (gnt !== 1'b1) begin errs++; $display("FAIL ill_gnt: got %0b want 1", gnt); end
    tick(); drive(1'b0, 6'd0, 32'd0, 32'd0);
    tick(); #1;
    vec++; if (rvalid !== 1'b1) begin errs++; $display("FAIL ill_rvalid: got %0b want 1", rvalid); end
    vec++; if (result !== 32'd0) begin errs++; $display("FAIL ill_result: got %0h want 0", result); end
    vec++; if (rflags !== 5'b10000) begin errs++; $display("FAIL ill_flags: got %0h want 10", rflags); end
  endtask

  task automatic test_reset_mid();
    int seen;
    // pipelined op flushed by reset
    tick(); drive(1'b1, 6'd0, 32'd10, 32'd20);
    tick(); drive(1'b0, 6'd0, 32'd0, 32'd0);
    tick(); drive(1'b1, 6'd0, 32'd5, 32'd5); #1;
    vec++; if (rvalid !== 1'b1 || result !== 32'd30) begin errs++; $display("FAIL rst_pre: got rv=%0b res=%0h want rv=1 res=1e", rvalid, result); end
    tick(); drive(1'b0, 6'd0, 32'd0, 32'd0); rst_n = 1'b0;
    tick(); rst_n = 1'b1; #1;
    vec++; if (rvalid !== 1'b0 || result !== 32'd0 || rflags !== 5'd0 || busy !== 1'b0) begin
      errs++; $display("FAIL rst_pipe: got rv=%0b res=%0h fl=%0h busy=%0b want all 0", rvalid, result, rflags, busy);
    end
    drive(1'b1, 6'd0, 32'd1, 32'd1); #1;
    vec++; if (gnt !== 1'b1) begin errs++; $display("FAIL rst_pipe_regnt: got %0b want 1", gnt); end
    tick(); drive(1'b0, 6'd0, 32'd0, 32'd0);
    tick(); #1;
    vec++; if (rvalid !== 1'b1 || result !== 32'd2) begin errs++; $display("FAIL rst_pipe_add: got rv=%0b res=%0h want rv=1 res=2", rvalid, result); end
    // divider flushed by reset at cycle 10 of the division
    tick(); drive(1'b1, 6'd5, 32'd1000, 32'd3); #1;
    vec++; if (gnt !== 1'b1) begin errs++; $display("FAIL rst_div_gnt: got %0b want 1", gnt); end
    for (int k = 1; k <= 10; k++) begin
      tick(); drive(1'b0, 6'd0, 32'd0, 32'd0);
    end
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; #1;
    vec++; if (rvalid !== 1'b0 || result !== 32'd0 || rflags !== 5'd0 || busy !== 1'b0) begin
      errs++; $display("FAIL rst_div: got rv=%0b res=%0h fl=%0h busy=%0b want all 0", rvalid, result, rflags, busy);
    end
    drive(1'b1, 6'd0, 32'd1, 32'd1); #1;
    vec++; if (gnt !== 1'b1) begin errs++; $display("FAIL rst_div_regnt: got %0b want 1", gnt); end
    tick(); drive(1'b0, 6'd0, 32'd0, 32'd0);
    tick(); #1;
    vec++; if (rvalid !== 1'b1 || result !== 32'd2) begin errs++; $display("FAIL rst_div_add: got rv=%0b res=%0h want rv=1 res=2", rvalid, result); end
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick(); #1;
      if (rvalid === 1'b1) seen++;
    end
    vec++; if (seen !== 0) begin errs++; $display("FAIL rst_div_ghost: got %0d stray rvalid want 0", seen); end
  endtask

  // Sequencer and final report
  initial begin
    vec  = 0;
    errs = 0;
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    rst_n = 1'b0;
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_divu();
    test_order();
    test_dz_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
